// File: rtl/vslc_pkg.sv
// vslc_pkg: shared address width and goto handshake states for the VSLC prefetch path
package vslc_pkg;
    localparam int ADDR_W = 10;
    typedef enum logic [1:0] {
        GT_IDLE = 2'd0,
        GT_LOW  = 2'd1,
        GT_HIGH = 2'd2
    } gt_state_e;
endpackage

// File: rtl/tt_um_jimktrains_vslc_prefetch_buffer_if.sv
// tt_um_jimktrains_vslc_prefetch_buffer_if: tagged byte stream from the prefetch FIFO head to the core
interface tt_um_jimktrains_vslc_prefetch_buffer_if #(
    parameter int ADDR_W = vslc_pkg::ADDR_W
);
    logic              out_valid;
    logic [7:0]        out_byte;
    logic [ADDR_W-1:0] out_addr;
    logic              out_ready;
    modport master(output out_valid, output out_byte, output out_addr, input out_ready);
    modport slave(input out_valid, input out_byte, input out_addr, output out_ready);
endinterface

// File: rtl/tt_um_jimktrains_vslc_byte_fifo.sv
// tt_um_jimktrains_vslc_byte_fifo: small FIFO of address-tagged bytes with flush and occupancy count
module tt_um_jimktrains_vslc_byte_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din_byte,
    input  logic [ADDR_W-1:0]        din_addr,
    output logic [7:0]               head_byte,
    output logic [ADDR_W-1:0]        head_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [7+ADDR_W:0] mem_q [DEPTH];
    logic [7+ADDR_W:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              do_push, do_pop;

    always_comb begin
        do_push = push && !flush;
        do_pop  = pop && !empty && !flush;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = {din_byte, din_addr};
        wr_d  = flush ? '0 : wr_q + PW'(do_push);
        rd_d  = flush ? '0 : rd_q + PW'(do_pop);
        cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign {head_byte, head_addr} = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/tt_um_jimktrains_vslc_prefetch_buffer.sv
// tt_um_jimktrains_vslc_prefetch_buffer: captures reader bytes by expected address, queues them for the core,
// throttles the reader with hold_n and drives goto_address/address on core jumps.
module tt_um_jimktrains_vslc_prefetch_buffer #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_W     = vslc_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]     RESET_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_clk,
    input  logic                     read_ready,
    input  logic [7:0]               byte_read,
    input  logic [ADDR_W-1:0]        address_read,
    output logic                     hold_n,
    output logic                     goto_address,
    output logic [ADDR_W-1:0]        address,
    input  logic                     jump_req,
    input  logic [ADDR_W-1:0]        jump_addr,
    tt_um_jimktrains_vslc_prefetch_buffer_if.master out_if,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    import vslc_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;

    gt_state_e         st_q, st_d;
    logic              rr_q, spi_q, goto_q, goto_d, ovf_q, ovf_d;
    logic [ADDR_W-1:0] exp_q, exp_d, addr_q, addr_d;
    logic              capture, spi_neg, match, push, pop, full, empty;

    always_comb begin
        capture = read_ready && !rr_q && st_q == GT_IDLE;
        spi_neg = spi_q && !spi_clk;
        match   = capture && address_read == exp_q && !jump_req;
        pop     = out_if.out_valid && out_if.out_ready && !jump_req;
        push    = match && (!full || pop);
        exp_d   = jump_req ? jump_addr : push ? exp_q + 1'b1 : exp_q;
        addr_d  = jump_req ? jump_addr : addr_q;
        ovf_d   = ovf_q || (match && full && !pop);
        // goto_address rises and falls on successive SPI negedges so the reader samples a clean edge
        st_d    = jump_req ? GT_LOW
                : !spi_neg ? st_q
                : st_q == GT_LOW ? GT_HIGH
                : st_q == GT_HIGH ? GT_IDLE
                : st_q;
        goto_d  = jump_req ? 1'b0
                : (spi_neg && st_q == GT_LOW) ? 1'b1
                : (spi_neg && st_q == GT_HIGH) ? 1'b0
                : goto_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= GT_IDLE;
            rr_q   <= 1'b0;
            spi_q  <= 1'b0;
            goto_q <= 1'b0;
            ovf_q  <= 1'b0;
            exp_q  <= RESET_ADDR;
            addr_q <= RESET_ADDR;
        end else begin
            st_q   <= st_d;
            rr_q   <= read_ready;
            spi_q  <= spi_clk;
            goto_q <= goto_d;
            ovf_q  <= ovf_d;
            exp_q  <= exp_d;
            addr_q <= addr_d;
        end
    end

    tt_um_jimktrains_vslc_byte_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (jump_req),
        .din_byte  (byte_read),
        .din_addr  (address_read),
        .head_byte (out_if.out_byte),
        .head_addr (out_if.out_addr),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // one spare slot absorbs the byte already shifting when hold falls
    assign hold_n           = (count < CW'(DEPTH - 1)) || st_q != GT_IDLE;
    assign out_if.out_valid = !empty;
    assign goto_address     = goto_q;
    assign address          = addr_q;
    assign overflow         = ovf_q;
endmodule

// File: tb/tb_tt_um_jimktrains_vslc_prefetch_buffer.sv
// tb_tt_um_jimktrains_vslc_prefetch_buffer: randomized reader/core stimulus against a queue-based reference model
module tb_tt_um_jimktrains_vslc_prefetch_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 10;

    typedef struct {
        logic [7:0]    b;
        logic [AW-1:0] a;
    } ent_t;

    logic          clk = 0, rst_n = 0, spi_clk = 0, read_ready = 0, jump_req = 0, out_ready = 0;
    logic [7:0]    byte_read = 0;
    logic [AW-1:0] address_read = 0, jump_addr = 0;
    logic          hold_n, goto_address, overflow;
    logic [AW-1:0] address;
    logic [2:0]    count;

    tt_um_jimktrains_vslc_prefetch_buffer_if #(.ADDR_W(AW)) oif ();
    assign oif.out_ready = out_ready;

    tt_um_jimktrains_vslc_prefetch_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .RESET_ADDR(10'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_clk      (spi_clk),
        .read_ready   (read_ready),
        .byte_read    (byte_read),
        .address_read (address_read),
        .hold_n       (hold_n),
        .goto_address (goto_address),
        .address      (address),
        .jump_req     (jump_req),
        .jump_addr    (jump_addr),
        .out_if       (oif.master),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    initial forever begin
        repeat (2) @(posedge clk);
        #1 spi_clk = ~spi_clk;
    end

    int npass = 0, ntot = 0, peak = 0, grise = 0;
    bit gprev = 0, ok;

    function automatic void chk(string n, int act, int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endfunction

    // reference model: a queue of accepted bytes, an occupancy count, the next wanted tag,
    // and the number of SPI negedges still owed to the goto handshake
    ent_t          sb[$];
    int            mcnt = 0, gbusy = 0;
    logic [AW-1:0] mexp = 0, maddr = 0;
    bit            movf = 0, m_rr = 0, m_spi = 0, rise, neg;

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            sb.delete();
            mcnt = 0; gbusy = 0; mexp = 0; maddr = 0; movf = 0; m_rr = 0; m_spi = 0;
        end else begin
            rise = read_ready && !m_rr;
            neg  = m_spi && !spi_clk;
            if (jump_req) begin
                sb.delete();
                mcnt = 0; mexp = jump_addr; maddr = jump_addr; gbusy = 2;
            end else begin
                if (mcnt > 0 && out_ready) mcnt--;
                if (rise && gbusy == 0 && address_read == mexp) begin
                    if (mcnt < DEPTH) begin
                        sb.push_back('{byte_read, address_read});
                        mcnt++;
                        mexp++;
                    end else movf = 1;
                end
                if (gbusy > 0 && neg) gbusy--;
            end
            m_rr  = read_ready;
            m_spi = spi_clk;
        end
    end

    ent_t e;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("out_valid", oif.out_valid, mcnt > 0);
            chk("count", count, mcnt);
            chk("hold_n", hold_n, (mcnt < DEPTH - 1) || gbusy > 0);
            chk("address", address, maddr);
            chk("goto_address", goto_address, gbusy == 1);
            chk("overflow", overflow, movf);
            if (count > peak) peak = count;
            if (goto_address && !gprev) grise++;
            gprev = goto_address;
            if (oif.out_valid && out_ready && !jump_req) begin
                if (sb.size() == 0) begin
                    ntot++;
                    $display("FAIL pop_unexpected: got addr %0h with empty scoreboard", oif.out_addr);
                end else begin
                    e = sb.pop_front();
                    chk("out_byte", oif.out_byte, e.b);
                    chk("out_addr", oif.out_addr, e.a);
                end
            end
        end
    end

    task automatic send(input logic [AW-1:0] tag, input bit pop_now, output bit h);
        read_ready   = 1;
        address_read = tag;
        byte_read    = 8'($urandom);
        h = hold_n;
        if (pop_now) out_ready = 1;
        @(posedge clk); #1;
        if (pop_now) out_ready = 0;
        repeat (2) begin @(posedge clk); #1; end
        read_ready = 0;
        @(posedge clk); #1;
    endtask

    task automatic jump(input logic [AW-1:0] a);
        jump_req  = 1;
        jump_addr = a;
        @(posedge clk); #1;
        jump_req = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (gbusy != 0 && n < 100) begin @(posedge clk); #1; n++; end
        if (n == 100) begin ntot++; $display("FAIL wait_idle: goto handshake still busy after %0d cycles", n); end
    endtask

    task automatic wait_hold();
        int n = 0;
        while (!hold_n && n < 200) begin @(posedge clk); #1; n++; end
        if (n == 200) begin ntot++; $display("FAIL wait_hold: hold_n still 0 after %0d cycles", n); end
    endtask

    task automatic wait_goto_high();
        int n = 0;
        while (!goto_address && n < 50) begin @(posedge clk); #1; n++; end
        if (n == 50) begin ntot++; $display("FAIL wait_goto: goto_address never rose within %0d cycles", n); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", oif.out_valid, 0);
        chk("rst_out_byte", oif.out_byte, 0);
        chk("rst_out_addr", oif.out_addr, 0);
        chk("rst_count", count, 0);
        chk("rst_hold_n", hold_n, 1);
        chk("rst_goto", goto_address, 0);
        chk("rst_address", address, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // in-order streaming with the core always ready
        out_ready = 1; peak = 0;
        for (int t = 0; t < 4; t++) send(AW'(t), 0, ok);
        repeat (3) @(posedge clk); #1;
        chk("s1_peak", peak, 1);

        // core stalled; reader honours hold_n sampled when it starts each byte
        out_ready = 0; peak = 0; ok = 1;
        for (int t = 4; t < 8; t++) send(AW'(t), 0, ok);
        @(posedge clk); #1;
        chk("s2_hold_seen", ok, 0);
        chk("s2_peak", peak, 4);
        chk("s2_overflow", overflow, 0);
        out_ready = 1;
        for (int t = 8; t < 12; t++) begin
            if (!ok) wait_hold();
            send(AW'(t), 0, ok);
        end
        repeat (4) @(posedge clk); #1;

        // ignore hold_n: the fifth byte is lost and overflow sticks
        out_ready = 0;
        for (int t = 12; t < 17; t++) send(AW'(t), 0, ok);
        chk("s3_overflow", overflow, 1);
        chk("s3_count", count, 4);
        out_ready = 1;
        repeat (8) @(posedge clk); #1;
        chk("s3_sticky", overflow, 1);
        send(AW'(16), 0, ok);
        repeat (3) @(posedge clk); #1;
        chk("s3_retry_drained", sb.size(), 0);
        rst_n = 0;
        repeat (2) @(posedge clk); #1;
        chk("s3_ovf_cleared", overflow, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // jump with tags 4,5 queued; stale tag 6 must vanish
        for (int t = 0; t < 4; t++) send(AW'(t), 0, ok);
        repeat (3) @(posedge clk); #1;
        out_ready = 0;
        send(AW'(4), 0, ok);
        send(AW'(5), 0, ok);
        chk("s4_count", count, 2);
        grise = 0;
        jump(10'h123);
        @(negedge clk);
        chk("s4_flushed", oif.out_valid, 0);
        chk("s4_address", address, 10'h123);
        @(posedge clk); #1;
        send(AW'(6), 0, ok);
        wait_idle();
        chk("s4_goto_pulses", grise, 1);
        out_ready = 1;
        send(10'h123, 0, ok);
        send(10'h124, 0, ok);
        repeat (3) @(posedge clk); #1;

        // re-jump while goto_address is high restarts the handshake
        grise = 0;
        jump(10'h150);
        wait_goto_high();
        jump(10'h200);
        wait_idle();
        chk("s5_goto_pulses", grise, 2);
        send(10'h200, 0, ok);
        send(10'h201, 0, ok);
        repeat (3) @(posedge clk); #1;

        // full FIFO with simultaneous push and pop across the address wrap
        jump(10'h3FB);
        wait_idle();
        out_ready = 0;
        for (int t = 'h3FB; t < 'h3FF; t++) send(AW'(t), 0, ok);
        send(10'h3FF, 1, ok);
        chk("s6_count_3ff", count, 4);
        send(10'h000, 1, ok);
        chk("s6_count_000", count, 4);
        chk("s6_overflow", overflow, 0);
        out_ready = 1;
        send(10'h001, 0, ok);
        repeat (6) @(posedge clk); #1;
        chk("s6_drained", sb.size(), 0);

        // random mix of matching and stale tags, jumps and core stalls
        for (int i = 0; i < 150; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       jump(AW'($urandom));
                1:       send(mexp + AW'($urandom_range(1, 3)), 0, ok);
                default: send(mexp, 0, ok);
            endcase
        end
        out_ready = 1;
        wait_idle();
        repeat (8) @(posedge clk); #1;
        chk("rand_drained", sb.size(), 0);

        // asynchronous reset in the middle of a byte
        out_ready = 0;
        send(mexp, 0, ok);
        read_ready = 1; address_read = mexp;
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("arst_out_valid", oif.out_valid, 0);
        chk("arst_out_byte", oif.out_byte, 0);
        chk("arst_count", count, 0);
        chk("arst_hold_n", hold_n, 1);
        chk("arst_address", address, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_goto", goto_address, 0);
        read_ready = 0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        out_ready = 1;
        send(10'h000, 0, ok);
        repeat (3) @(posedge clk); #1;
        chk("post_rst_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
